// File: rtl/serdes_pkg.sv
// Shared constants for the serial/parallel converters.
package serdes_pkg;
    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned BIT_ORDER_LSB = 1;
    localparam int unsigned BIT_ORDER_MSB = 0;
endpackage

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter: assembles WIDTH-bit words from qualified serial bits and
// emits them automatically or on a latch strobe, with resync, short-word and overrun flags.
module shift_deserializer
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned LSB_FIRST  = BIT_ORDER_LSB,
    parameter int unsigned AUTO_LATCH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         data,
    input  logic                         bit_valid,
    input  logic                         frame_sync,
    input  logic                         latch,
    output logic [WIDTH-1:0]             dataOut,
    output logic                         out_valid,
    output logic                         short_word,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count,
    output logic                         overrun
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_short_word;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_sync_shreg;
    logic [WIDTH-1:0] w_post_shreg;
    logic [CW-1:0]    w_post_count;
    logic             w_full;
    logic             w_emit;

    // Bit-order specific shift and the first bit landing in a freshly cleared register
    if (LSB_FIRST == BIT_ORDER_LSB) begin : g_lsb
        assign w_shifted    = {data, r_shreg[WIDTH-1:1]};
        assign w_sync_shreg = bit_valid ? {data, {(WIDTH-1){1'b0}}} : '0;
    end else begin : g_msb
        assign w_shifted    = {r_shreg[WIDTH-2:0], data};
        assign w_sync_shreg = bit_valid ? {{(WIDTH-1){1'b0}}, data} : '0;
    end

    assign w_full       = (r_count == CW'(WIDTH));
    assign w_post_shreg = bit_valid ? w_shifted : r_shreg;

    // Count saturates at WIDTH; only reachable in manual mode
    always_comb begin
        w_post_count = r_count;
        if (bit_valid && !w_full) begin
            w_post_count = r_count + CW'(1);
        end
    end

    assign w_emit = (AUTO_LATCH != 0) ? (bit_valid && (r_count == CW'(WIDTH - 1))) : latch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg      <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            r_short_word <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_out_valid  <= 1'b0;
            r_short_word <= 1'b0;
            if (frame_sync) begin
                r_shreg   <= w_sync_shreg;
                r_count   <= CW'(bit_valid);
                r_overrun <= 1'b0;
            end else if (w_emit) begin
                r_data_out   <= w_post_shreg;
                r_out_valid  <= 1'b1;
                r_short_word <= (w_post_count < CW'(WIDTH));
                r_shreg      <= '0;
                r_count      <= '0;
            end else begin
                r_shreg <= w_post_shreg;
                r_count <= w_post_count;
                if (bit_valid && w_full) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign dataOut    = r_data_out;
    assign out_valid  = r_out_valid;
    assign short_word = r_short_word;
    assign bit_count  = r_count;
    assign overrun    = r_overrun;

endmodule
